// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select, a single
// outstanding addr_ok/data_ok fetch, and the IF/ID register for decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        BranchD,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        EPC_sel,
    input  logic        exception,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] Jump_addr,
    input  logic [31:0] PCSrc_reg,
    input  logic [31:0] EPCout,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instr,
    output logic [31:0] PCin,
    output logic [31:0] pc_plus_4,
    output logic        ValidD,
    output logic        AdELF,
    output logic        StallF
);

    localparam logic [1:0] S_REQ    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_CANCEL = 2'd3;

    // Redirect priority levels; a larger value wins.
    localparam logic [2:0] L_NONE = 3'd0;
    localparam logic [2:0] L_BR   = 3'd1;
    localparam logic [2:0] L_J    = 3'd2;
    localparam logic [2:0] L_JR   = 3'd3;
    localparam logic [2:0] L_EPC  = 3'd4;
    localparam logic [2:0] L_EXC  = 3'd5;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] pc_inc;

    logic        pending_v;
    logic [2:0]  pending_lvl;
    logic [31:0] pending_pc;

    logic [31:0] hold_word;

    logic [2:0]  in_lvl;
    logic [31:0] in_pc;
    logic        use_in;
    logic        redir_v;
    logic [2:0]  redir_lvl;
    logic [31:0] redir_pc;

    logic        flush;
    logic        misal;
    logic        pc_upd;
    logic        deliver;
    logic        load_word;
    logic        park;
    logic        adel_f;
    logic [31:0] word;

    assign pc_inc = pc + 32'd4;
    assign flush  = exception | EPC_sel;
    assign misal  = (pc[1:0] != 2'b00);

    // Highest-priority redirect presented this cycle
    always_comb begin
        in_lvl = L_NONE;
        in_pc  = 32'd0;
        if (exception) begin
            in_lvl = L_EXC;
            in_pc  = EXC_VECTOR;
        end else if (EPC_sel) begin
            in_lvl = L_EPC;
            in_pc  = EPCout;
        end else if (JumpReg) begin
            in_lvl = L_JR;
            in_pc  = PCSrc_reg;
        end else if (Jump) begin
            in_lvl = L_J;
            in_pc  = Jump_addr;
        end else if (BranchD) begin
            in_lvl = L_BR;
            in_pc  = Branch_addr;
        end
    end

    // Merge the live redirect with the latched one; ties go to the newer
    always_comb begin
        use_in    = (in_lvl != L_NONE) &&
                    (!pending_v || (in_lvl >= pending_lvl));
        redir_v   = use_in || pending_v;
        redir_lvl = use_in ? in_lvl : pending_lvl;
        redir_pc  = use_in ? in_pc : pending_pc;
        pc_n      = redir_v ? redir_pc : pc_inc;
    end

    // Fetch FSM: next state, word delivery and PC update strobe
    always_comb begin
        state_n = state;
        pc_upd  = 1'b0;
        deliver = 1'b0;
        park    = 1'b0;
        adel_f  = 1'b0;
        word    = 32'd0;
        unique case (state)
            S_REQ: begin
                if (misal) begin
                    // Misaligned PC: no bus access, deliver an AdEL slot.
                    deliver = 1'b1;
                    adel_f  = 1'b1;
                    if (flush || !StallD) begin
                        pc_upd = 1'b1;
                    end
                end else if (inst_addr_ok) begin
                    state_n = flush ? S_CANCEL : S_WAIT;
                end else if (flush) begin
                    pc_upd = 1'b1;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    deliver = 1'b1;
                    word    = inst_rdata;
                    if (flush || !StallD) begin
                        state_n = S_REQ;
                        pc_upd  = 1'b1;
                    end else begin
                        state_n = S_HOLD;
                        park    = 1'b1;
                    end
                end else if (flush) begin
                    state_n = S_CANCEL;
                end
            end
            S_HOLD: begin
                deliver = 1'b1;
                word    = hold_word;
                if (flush || !StallD) begin
                    state_n = S_REQ;
                    pc_upd  = 1'b1;
                end
            end
            S_CANCEL: begin
                // Stale response is dropped; PC then takes the redirect.
                if (inst_data_ok) begin
                    state_n = S_REQ;
                    pc_upd  = 1'b1;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
        load_word = deliver && !flush && !StallD;
    end

    // FSM state, PC and latched redirect
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pending_v   <= 1'b0;
            pending_lvl <= L_NONE;
            pending_pc  <= 32'd0;
        end else begin
            state <= state_n;
            if (pc_upd) begin
                pc          <= pc_n;
                pending_v   <= 1'b0;
                pending_lvl <= L_NONE;
            end else begin
                pending_v   <= redir_v;
                pending_lvl <= redir_lvl;
                pending_pc  <= redir_pc;
            end
        end
    end

    // Park a returned word while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_word <= 32'd0;
        end else if (park) begin
            hold_word <= inst_rdata;
        end
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr     <= 32'd0;
            PCin      <= 32'd0;
            pc_plus_4 <= 32'd0;
            ValidD    <= 1'b0;
            AdELF     <= 1'b0;
        end else if (exception) begin
            instr  <= 32'd0;
            ValidD <= 1'b0;
            AdELF  <= 1'b0;
        end else if (!StallD) begin
            if (load_word) begin
                instr     <= word;
                PCin      <= pc;
                pc_plus_4 <= pc_inc;
                ValidD    <= 1'b1;
                AdELF     <= adel_f;
            end else begin
                instr  <= 32'd0;
                ValidD <= 1'b0;
                AdELF  <= 1'b0;
            end
        end
    end

    assign inst_req  = rst && (state == S_REQ) && !misal;
    assign inst_addr = pc;
    assign StallF    = (state != S_HOLD) || StallD;

endmodule
